// File: rtl/line_fill_responder.sv
// Memory-side responder for 16-byte cache line fills: four-beat READ/WRITE bursts after WAIT_STATES idle cycles.
// Define LFR_CRITICAL_WORD_FIRST_EN to start each burst at Ain[3:2] (wrapping) instead of longword 0.
module line_fill_responder #(
    parameter int MEM_AW      = 10,
    parameter int WAIT_STATES = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Ain,
    input  logic [2:0]  BR,
    input  logic [31:0] DIN,
    output logic [31:0] DOUT,
    output logic        ACK,
    output logic [1:0]  BEAT,
    output logic        BUSY,
    output logic        DONE
);
    localparam int LW = MEM_AW - 2;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_BURST, S_DONE} state_t;

    state_t        state, next_state;
    logic [LW-1:0] line_q, line_d;
    logic          is_write_q, is_write_d;
    logic [7:0]    wait_cnt, wait_cnt_d;
    logic [1:0]    beat_cnt, beat_cnt_d;
    logic [1:0]    beat_d, start_idx;
    logic [31:0]   dout_d;
    logic          ack_d, busy_d, done_d;
    logic          accept;

    logic [31:0] mem [2**MEM_AW];

    assign accept = (state == S_IDLE) && ((BR == 3'd1) || (BR == 3'd2));

`ifdef LFR_CRITICAL_WORD_FIRST_EN
    assign start_idx = Ain[3:2];
`else
    assign start_idx = 2'd0;
`endif

    // State register; outputs are registered alongside so every port comes from a flop.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state      <= S_IDLE;
            line_q     <= '0;
            is_write_q <= 1'b0;
            wait_cnt   <= 8'd0;
            beat_cnt   <= 2'd0;
            ACK        <= 1'b0;
            BEAT       <= 2'd0;
            BUSY       <= 1'b0;
            DONE       <= 1'b0;
            DOUT       <= 32'd0;
        end else begin
            state      <= next_state;
            line_q     <= line_d;
            is_write_q <= is_write_d;
            wait_cnt   <= wait_cnt_d;
            beat_cnt   <= beat_cnt_d;
            ACK        <= ack_d;
            BEAT       <= beat_d;
            BUSY       <= busy_d;
            DONE       <= done_d;
            DOUT       <= dout_d;
        end
    end

    always_comb begin
        next_state = state;
        unique case (state)
            S_IDLE:  if (accept) next_state = (WAIT_STATES == 0) ? S_BURST : S_WAIT;
            S_WAIT:  if (wait_cnt == 8'd1) next_state = S_BURST;
            S_BURST: if (beat_cnt == 2'd3) next_state = S_DONE;
            S_DONE:  if (BR == 3'd0) next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the branches so no latch is inferred.
    always_comb begin
        line_d     = line_q;
        is_write_d = is_write_q;
        wait_cnt_d = 8'd0;
        beat_cnt_d = 2'd0;
        beat_d     = BEAT;
        if (accept) begin
            line_d     = Ain[MEM_AW+1:4];
            is_write_d = (BR == 3'd2);
            wait_cnt_d = 8'(WAIT_STATES);
            beat_d     = start_idx;
        end else if (state == S_WAIT) begin
            wait_cnt_d = wait_cnt - 8'd1;
        end else if (state == S_BURST && next_state == S_BURST) begin
            beat_d     = BEAT + 2'd1;
            beat_cnt_d = beat_cnt + 2'd1;
        end
        ack_d  = (next_state == S_BURST);
        busy_d = (next_state != S_IDLE);
        done_d = (next_state == S_DONE);
        // Read data is fetched for the beat about to be presented, so it lands with ACK.
        dout_d = (ack_d && !is_write_d) ? mem[{line_d, beat_d}] : 32'd0;
    end

    // NOTE: the RAM has no reset; only the write enable is gated by RESET so an abandoned burst stops writing.
    always_ff @(posedge CLK) begin
        if (!RESET && state == S_BURST && is_write_q)
            mem[{line_q, BEAT}] <= DIN;
    end
endmodule

// File: tb/tb_line_fill_responder.sv
// Directed bench for line_fill_responder: table of bursts plus hand-written hold, reserved, zero-wait and reset cases.
module tb_line_fill_responder;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] ain, din, dout, din_base;
    logic [2:0]  br;
    logic        ack, busy, done;
    logic [1:0]  beat;
    logic [31:0] ain0, din0, dout0, din_base0;
    logic [2:0]  br0;
    logic        ack0, busy0, done0;
    logic [1:0]  beat0;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    // Requester derives write data combinationally from BEAT.
    assign din  = din_base  + {30'd0, beat};
    assign din0 = din_base0 + {30'd0, beat0};

    line_fill_responder #(.MEM_AW(10), .WAIT_STATES(2)) dut (
        .CLK(clk), .RESET(rst), .Ain(ain), .BR(br), .DIN(din),
        .DOUT(dout), .ACK(ack), .BEAT(beat), .BUSY(busy), .DONE(done)
    );

    line_fill_responder #(.MEM_AW(10), .WAIT_STATES(0)) dut0 (
        .CLK(clk), .RESET(rst), .Ain(ain0), .BR(br0), .DIN(din0),
        .DOUT(dout0), .ACK(ack0), .BEAT(beat0), .BUSY(busy0), .DONE(done0)
    );

    typedef struct packed {
        logic [2:0]       br;
        logic [31:0]      ain;
        logic [31:0]      dbase;
        logic [3:0][31:0] exp_d;
        logic [3:0][1:0]  exp_b;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [2:0] b, input logic [31:0] a, input logic [31:0] base,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [31:0] d2, input logic [31:0] d3,
                                input logic [1:0] b0, input logic [1:0] b1,
                                input logic [1:0] b2, input logic [1:0] b3);
        vec_t v;
        v.br = b; v.ain = a; v.dbase = base;
        v.exp_d[0] = d0; v.exp_d[1] = d1; v.exp_d[2] = d2; v.exp_d[3] = d3;
        v.exp_b[0] = b0; v.exp_b[1] = b1; v.exp_b[2] = b2; v.exp_b[3] = b3;
        return v;
    endfunction

    // One full request on the WAIT_STATES=2 instance, checked cycle by cycle.
    task automatic run_burst(input int idx, input vec_t v);
        @(posedge clk); #1;
        br = v.br; ain = v.ain; din_base = v.dbase;
        @(posedge clk); #1;
        check($sformatf("v%0d_wait1_busy", idx), {31'd0, busy}, 32'd1);
        check($sformatf("v%0d_wait1_ack", idx), {31'd0, ack}, 32'd0);
        @(posedge clk); #1;
        check($sformatf("v%0d_wait2_ack", idx), {31'd0, ack}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("v%0d_b%0d_ack", idx, i), {31'd0, ack}, 32'd1);
            check($sformatf("v%0d_b%0d_beat", idx, i), {30'd0, beat}, {30'd0, v.exp_b[i]});
            check($sformatf("v%0d_b%0d_dout", idx, i), dout, v.exp_d[i]);
        end
        @(posedge clk); #1;
        check($sformatf("v%0d_done", idx), {29'd0, done, busy, ack}, 32'd6);
        br = 3'd0;
        @(posedge clk); #1;
        check($sformatf("v%0d_idle", idx), {30'd0, done, busy}, 32'd0);
    endtask

    initial begin
        int n_ack, n_done;
        rst = 1'b1; br = 3'd0; ain = 32'd0; din_base = 32'd0;
        br0 = 3'd0; ain0 = 32'd0; din_base0 = 32'd0;

        vecs[0] = mk(3'd2, 32'h0000_0400, 32'h0000_00A0, 0, 0, 0, 0, 0, 1, 2, 3);
        vecs[1] = mk(3'd1, 32'h0000_0400, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1, 2, 3);
        vecs[2] = mk(3'd2, 32'h0000_0810, 32'h1111_0000, 0, 0, 0, 0, 0, 1, 2, 3);
        vecs[3] = mk(3'd1, 32'h0000_0810, 32'h0, 32'h1111_0000, 32'h1111_0001,
                     32'h1111_0002, 32'h1111_0003, 0, 1, 2, 3);
`ifdef LFR_CRITICAL_WORD_FIRST_EN
        vecs[4] = mk(3'd1, 32'h0000_040C, 32'h0, 32'hA3, 32'hA0, 32'hA1, 32'hA2, 3, 0, 1, 2);
`else
        vecs[4] = mk(3'd1, 32'h0000_040C, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1, 2, 3);
`endif
        // Address bit 12 is above the RAM index and aliases onto line 0x40.
        vecs[5] = mk(3'd1, 32'h0000_1400, 32'h0, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 1, 2, 3);
        vecs[6] = mk(3'd2, 32'h0000_0820, 32'h3333_0000, 0, 0, 0, 0, 0, 1, 2, 3);

        repeat (3) @(posedge clk);
        #1;
        check("rst_outputs", {27'd0, ack, done, busy, beat}, 32'd0);
        check("rst_dout", dout, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_after_rst", {27'd0, ack, done, busy, beat}, 32'd0);

        for (int i = 0; i < 7; i++) run_burst(i, vecs[i]);

        // Held request: served once, DONE/BUSY held until BR drops.
        @(posedge clk); #1;
        br = 3'd1; ain = 32'h0000_0400;
        n_ack = 0;
        repeat (6) begin @(posedge clk); #1; n_ack += int'(ack); end
        check("held_acks", n_ack, 4);
        n_ack = 0; n_done = 0;
        repeat (20) begin @(posedge clk); #1; n_ack += int'(ack); n_done += int'(done & busy); end
        check("held_no_reserve", n_ack, 0);
        check("held_done_busy", n_done, 20);
        br = 3'd0;
        @(posedge clk); #1;
        check("held_release", {30'd0, done, busy}, 32'd0);

        // Reserved request code is ignored.
        br = 3'd3; ain = 32'h0000_0400;
        n_ack = 0; n_done = 0;
        repeat (5) begin @(posedge clk); #1; n_ack += int'(ack); n_done += int'(busy); end
        check("rsvd_ack", n_ack, 0);
        check("rsvd_busy", n_done, 0);
        br = 3'd0;

        // Zero wait states: first ACK right after acceptance.
        @(posedge clk); #1;
        br0 = 3'd2; ain0 = 32'h0000_0000; din_base0 = 32'h0000_5500;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("ws0_wr_b%0d_ack", i), {31'd0, ack0}, 32'd1);
            check($sformatf("ws0_wr_b%0d_beat", i), {30'd0, beat0}, i);
        end
        @(posedge clk); #1;
        check("ws0_wr_done", {31'd0, done0}, 32'd1);
        br0 = 3'd0;
        @(posedge clk); #1;
        br0 = 3'd1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check($sformatf("ws0_rd_b%0d_ack", i), {31'd0, ack0}, 32'd1);
            check($sformatf("ws0_rd_b%0d_dout", i), dout0, 32'h0000_5500 + i);
        end
        @(posedge clk); #1;
        br0 = 3'd0;

        // Reset during the 2nd beat of a WRITE over line 0x82 (pre-filled 0x3333000x).
        @(posedge clk); #1;
        br = 3'd2; ain = 32'h0000_0820; din_base = 32'h4444_0000;
        repeat (4) @(posedge clk);
        #1;
        check("rstmid_beat1_ack", {30'd0, ack, beat}, 32'd5);
        rst = 1'b1; br = 3'd0;
        @(posedge clk); #1;
        check("rstmid_outputs", {27'd0, ack, done, busy, beat}, 32'd0);
        check("rstmid_dout", dout, 32'd0);
        rst = 1'b0;
        run_burst(7, mk(3'd1, 32'h0000_0820, 32'h0, 32'h4444_0000, 32'h3333_0001,
                        32'h3333_0002, 32'h3333_0003, 0, 1, 2, 3));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/line_fill_responder.md
# line_fill_responder

Memory-side responder for the cache line-fill bus. Serves the 16-byte line requests that the instruction and data caches issue on `BR`/`Ain`. Returns or accepts four longwords per request as a counted burst after a programmable wait-state delay. Holds a word-addressed backing RAM, so the caches can be exercised and benchmarked without an external memory model.

## Interface
Parameters:
- `MEM_AW`, 10 — backing RAM word-address width (2**MEM_AW longwords).
- `WAIT_STATES`, 2 — idle cycles between request acceptance and first beat; legal 0..255.

Ports:
- `CLK` in 1 — the single clock; all logic on its rising edge.
- `RESET` in 1 — synchronous, active-high reset.
- `Ain` in 32 — request address; line base is `Ain[31:4]`, `Ain[3:2]` is the requested longword.
- `BR` in 3 — bus request: 0 NONE, 1 READ, 2 WRITE; 3..7 reserved.
- `DIN` in 32 — write data for the beat indicated by `BEAT` while `ACK`=1.
- `DOUT` out 32 — read data; valid only while `ACK`=1 on a READ.
- `ACK` out 1 — beat strobe, one cycle per longword.
- `BEAT` out 2 — longword index (L0..L3) of the current beat.
- `BUSY` out 1 — request in progress (WAIT, BURST or DONE).
- `DONE` out 1 — burst complete; held until `BR` returns to NONE.

## Operation
- States: IDLE, WAIT, BURST, DONE.
- IDLE:
  - `BR`=1 or 2 at an edge latches `Ain[31:4]`, the direction, and the start index.
  - Goes to WAIT, or straight to BURST when `WAIT_STATES`=0.
  - Reserved `BR` values are ignored; the block stays in IDLE.
- WAIT: an 8-bit counter loaded with `WAIT_STATES` decrements each cycle; at 1 → BURST.
- BURST:
  - Exactly 4 cycles with `ACK`=1; `BEAT` advances by +1 modulo 4 each beat (wrap 3→0).
  - READ: `DOUT` = mem[{line, BEAT}].
  - WRITE: mem[{line, BEAT}] ← `DIN`, sampled at the edge ending each `ACK` cycle.
  - After beat 4 → DONE.
- DONE:
  - `DONE`=1, `BUSY`=1, `ACK`=0.
  - Stays until `BR`=NONE is sampled, then → IDLE.
  - A held `BR` is therefore never served twice.
- `BR`, `Ain` changes after acceptance are ignored until IDLE.
- RAM index is `{line, BEAT}[MEM_AW-1:0]`, i.e. Ain bits [MEM_AW+1:2]. Higher address bits alias.
- The RAM is not cleared by reset; initial contents are undefined unless loaded by the bench.

## Timing
- Request sampled at edge E0.
- First `ACK` is high in the cycle after edge E0+WAIT_STATES.
- Last `ACK` is high in the cycle after edge E0+WAIT_STATES+3.
- `DONE` rises one cycle after the last `ACK`.
- Minimum DONE duration is 1 cycle; the next request can be accepted at the first edge in IDLE.
- Minimum request-to-request spacing is WAIT_STATES+6 cycles.
- All outputs are registered.
- `DOUT` is zero outside READ beats.
- The requester may derive `DIN` combinationally from `BEAT`.
- Reset values: `ACK`=0, `DONE`=0, `BUSY`=0, `BEAT`=0, `DOUT`=0, state IDLE, wait counter 0.
- Reset mid-burst → IDLE next edge; the request is abandoned.
  - WRITE beats already acknowledged remain in RAM; no further RAM writes occur.
- `RESET` dominates `BR` in the same cycle.

## Configuration
- Macro `LFR_CRITICAL_WORD_FIRST_EN`.
- Defined: the start index is `Ain[3:2]`, so the requested longword arrives first and the burst wraps within the line. Example: start 2 gives the order 2,3,0,1.
- Undefined: the start index is always 0 (order 0,1,2,3); `Ain[3:2]` is ignored.
- Both builds always transfer exactly 4 beats covering all of L0..L3.

## Test plan
- Preload mem[0x100..0x103] = 0xA0..0xA3, WAIT_STATES=2, READ at `Ain`=0x400 → `ACK` in the 3rd..6th cycles after acceptance with `DOUT` 0xA0,0xA1,0xA2,0xA3 and `BEAT` 0..3; `DONE` rises in the 7th cycle.
- WRITE at `Ain`=0x810 with `DIN`=0x11110000+`BEAT` → mem[0x204..0x207] = 0x11110000..0x11110003; a following READ returns the same values.
- With macro defined, READ at `Ain`=0x40C → `BEAT` order 3,0,1,2. Without the macro, the same request gives order 0,1,2,3.
- Hold `BR`=READ for 20 cycles after `DONE` → exactly one burst; `DONE` stays 1 and `BUSY` stays 1 until `BR`=0, then both drop next cycle.
- `BR`=3 for 5 cycles → no `ACK`, `BUSY`=0. `WAIT_STATES`=0 → first `ACK` in the cycle right after acceptance.
- Assert `RESET` on the 2nd beat of a WRITE → all outputs 0 next cycle; only beat 0 is committed to RAM; a new READ completes normally.
